// File: rtl/mario_sprite_sched_if.sv
// Shared ROM bus between the sprite scheduler (master) and the three 32x32 sprite ROMs (slave).
// One registered address fans out to all ROMs; each ROM returns its word one cycle later.
interface mario_sprite_sched_if;
    logic [9:0]  rom_addr;
    logic [11:0] jr_data;
    logic [11:0] jl_data;
    logic [11:0] idle_data;

    modport master (output rom_addr, input jr_data, jl_data, idle_data);
    modport slave  (input rom_addr, output jr_data, jl_data, idle_data);
endinterface

// File: rtl/mario_sprite_sched.sv
// Mario sprite pose scheduler and ROM address sequencer, 3-cycle pixel pipeline.
// Optional MARIO_SPRITE_MIRROR_EN: idle pose mirrors its columns when facing left.
module mario_sprite_sched #(
    parameter logic [11:0] TRANSP_KEY = 12'hF0F,
    parameter int unsigned LAND_HOLD  = 3
) (
    input  logic                        clk,
    input  logic                        reset,
    input  logic                        frame_start,
    input  logic                        pix_valid,
    input  logic [9:0]                  hcount,
    input  logic [9:0]                  vcount,
    input  logic [9:0]                  mario_x,
    input  logic [9:0]                  mario_y,
    input  logic                        move_left,
    input  logic                        move_right,
    input  logic                        on_ground,
    mario_sprite_sched_if.master        rom,
    output logic [11:0]                 pixel_out,
    output logic                        pixel_opaque,
    output logic                        pixel_valid_out,
    output logic [1:0]                  pose
);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        JUMP_R = 2'd1,
        JUMP_L = 2'd2
    } pose_e;

    localparam logic [3:0] HOLD_INIT = 4'(LAND_HOLD);

    pose_e      pose_q, pose_d;
    logic       facing_left_q, facing_left_d;
    logic [3:0] hold_q, hold_d;

    // ---------------- pose FSM (advances only on frame_start) ----------------
    always_ff @(posedge clk) begin
        if (reset) begin
            pose_q        <= IDLE;
            facing_left_q <= 1'b0;
            hold_q        <= 4'd0;
        end else begin
            pose_q        <= pose_d;
            facing_left_q <= facing_left_d;
            hold_q        <= hold_d;
        end
    end

    always_comb begin
        pose_d        = pose_q;
        facing_left_d = facing_left_q;
        hold_d        = hold_q;
        if (frame_start) begin
            // The decision below must see this frame's facing, not last frame's.
            if (move_right && !move_left) begin
                facing_left_d = 1'b0;
            end else if (move_left && !move_right) begin
                facing_left_d = 1'b1;
            end
            case (pose_q)
                IDLE: begin
                    if (!on_ground) begin
                        pose_d = facing_left_d ? JUMP_L : JUMP_R;
                        hold_d = HOLD_INIT;
                    end
                end
                JUMP_R, JUMP_L: begin
                    if (!on_ground) begin
                        pose_d = facing_left_d ? JUMP_L : JUMP_R;
                        hold_d = HOLD_INIT;
                    end else if (hold_q == 4'd0) begin
                        pose_d = IDLE;
                    end else begin
                        hold_d = hold_q - 4'd1;
                    end
                end
                default: pose_d = IDLE;
            endcase
        end
    end

    assign pose = pose_q;

    // ---------------- stage 1: box test and address ----------------
    logic       in_box;
    logic [4:0] col, row, col_eff;
    logic [9:0] addr_q, addr_d;

    // 11-bit compare so a sprite near the right/bottom edge clips instead of wrapping.
    assign in_box = ({1'b0, hcount} >= {1'b0, mario_x}) &&
                    ({1'b0, hcount} <  ({1'b0, mario_x} + 11'd32)) &&
                    ({1'b0, vcount} >= {1'b0, mario_y}) &&
                    ({1'b0, vcount} <  ({1'b0, mario_y} + 11'd32));

    assign col = hcount[4:0] - mario_x[4:0];
    assign row = vcount[4:0] - mario_y[4:0];

`ifdef MARIO_SPRITE_MIRROR_EN
    assign col_eff = ((pose_q == IDLE) && facing_left_q) ? ~col : col;
`else
    assign col_eff = col;
`endif

    assign addr_d = in_box ? {row, col_eff} : addr_q;

    // Each pixel carries its own pose so a mid-pipeline pose change cannot corrupt it.
    logic  s1_in_box_q, s1_pv_q, s2_in_box_q, s2_pv_q;
    pose_e s1_pose_q, s2_pose_q;

    always_ff @(posedge clk) begin
        if (reset) begin
            addr_q      <= 10'd0;
            s1_in_box_q <= 1'b0;
            s1_pv_q     <= 1'b0;
            s1_pose_q   <= IDLE;
            s2_in_box_q <= 1'b0;
            s2_pv_q     <= 1'b0;
            s2_pose_q   <= IDLE;
        end else begin
            addr_q      <= addr_d;
            s1_in_box_q <= in_box;
            s1_pv_q     <= pix_valid;
            s1_pose_q   <= pose_q;
            s2_in_box_q <= s1_in_box_q;
            s2_pv_q     <= s1_pv_q;
            s2_pose_q   <= s1_pose_q;
        end
    end

    assign rom.rom_addr = addr_q;

    // ---------------- stage 3: data select, colour key, output ----------------
    logic [11:0] sel_data;
    logic        opaque_d;
    logic [11:0] pixel_q;
    logic        opaque_q, valid_q;

    always_comb begin
        sel_data = rom.idle_data;
        case (s2_pose_q)
            JUMP_R:  sel_data = rom.jr_data;
            JUMP_L:  sel_data = rom.jl_data;
            default: sel_data = rom.idle_data;
        endcase
    end

    assign opaque_d = s2_in_box_q && s2_pv_q && (sel_data != TRANSP_KEY);

    always_ff @(posedge clk) begin
        if (reset) begin
            pixel_q  <= 12'd0;
            opaque_q <= 1'b0;
            valid_q  <= 1'b0;
        end else begin
            pixel_q  <= opaque_d ? sel_data : 12'd0;
            opaque_q <= opaque_d;
            valid_q  <= s2_pv_q;
        end
    end

    assign pixel_out       = pixel_q;
    assign pixel_opaque    = opaque_q;
    assign pixel_valid_out = valid_q;

endmodule
